// File: rtl/led_seq_pkg.sv
// Shared types and pattern rules for the LED pattern sequencer.
// Mode/state enums, PWM width, and the init/step pattern functions.
package led_seq_pkg;

    localparam int unsigned PWM_W     = 4;
    localparam int unsigned PAT_MAX_W = 32;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_BLINK = 2'd1,
        MODE_CHASE = 2'd2,
        MODE_COUNT = 2'd3
    } led_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2
    } seq_state_e;

    // All-ones mask for a pattern of width w (w <= PAT_MAX_W)
    function automatic logic [PAT_MAX_W-1:0] pattern_mask(
        input int unsigned w
    );
        logic [PAT_MAX_W-1:0] m;
        if (w >= PAT_MAX_W) m = '1;
        else m = (32'd1 << w) - 32'd1;
        return m;
    endfunction

    function automatic logic [PAT_MAX_W-1:0] pattern_init(
        input led_mode_e   m,
        input int unsigned w
    );
        logic [PAT_MAX_W-1:0] p;
        case (m)
            MODE_BLINK: p = pattern_mask(w);
            MODE_CHASE: p = 32'd1;
            default:    p = '0;
        endcase
        return p;
    endfunction

    function automatic logic [PAT_MAX_W-1:0] pattern_step(
        input led_mode_e            m,
        input logic [PAT_MAX_W-1:0] p,
        input int unsigned          w
    );
        logic [PAT_MAX_W-1:0] mk;
        logic [PAT_MAX_W-1:0] n;
        mk = pattern_mask(w);
        case (m)
            MODE_BLINK: n = ~p & mk;
            // rotate left within w bits: MSB re-enters at bit 0
            MODE_CHASE: n = ((p << 1) | (p >> (w - 1))) & mk;
            MODE_COUNT: n = (p + 32'd1) & mk;
            default:    n = '0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/led_step_prescaler.sv
// Step-rate prescaler: counts 0..DIV-1 and pulses tick_o on the last count.
// Ports: clk, rst (sync high), clear_i (hold at 0, no tick), tick_o.
module led_step_prescaler #(
    parameter int unsigned DIV = 12_500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    output logic tick_o
);

    localparam int unsigned CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = !clear_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clear_i || tick_o) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// LED bank sequencer: OFF/BLINK/CHASE/COUNT patterns stepped by a prescaler;
// mode requests via valid/ready, applied only on step boundaries.
// Ports: clk, rst, run, mode_valid, mode[1:0], mode_ready, led, busy,
// step_tick; with LED_PWM_EN defined also bright[3:0] (per-bit PWM gate).
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int unsigned STEP_DIV = 12_500_000,
    parameter int unsigned NUM_LEDS = 5
) (
    input  logic                clk,
    input  logic                rst,
`ifdef LED_PWM_EN
    input  logic [PWM_W-1:0]    bright,
`endif
    input  logic                run,
    input  logic                mode_valid,
    input  logic [1:0]          mode,
    output logic                mode_ready,
    output logic [NUM_LEDS-1:0] led,
    output logic                busy,
    output logic                step_tick
);

    seq_state_e state_q, state_d;
    led_mode_e  cur_q, cur_d;
    led_mode_e  pend_q, pend_d;

    logic [NUM_LEDS-1:0] pat_q, pat_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic [NUM_LEDS-1:0] gate;

    logic tick;
    logic accept;
    led_mode_e req;

    led_step_prescaler #(
        .DIV (STEP_DIV)
    ) u_presc (
        .clk     (clk),
        .rst     (rst),
        .clear_i (state_q == ST_IDLE),
        .tick_o  (tick)
    );

    assign mode_ready = (state_q != ST_PEND);
    assign busy       = (state_q != ST_IDLE);
    assign step_tick  = tick;
    assign accept     = mode_valid && mode_ready;
    assign req        = led_mode_e'(mode);
    assign led        = led_q;

`ifdef LED_PWM_EN
    logic [PWM_W-1:0] pwm_q;

    always_ff @(posedge clk) begin
        if (rst) pwm_q <= '0;
        else     pwm_q <= pwm_q + PWM_W'(1);
    end

    assign gate = {NUM_LEDS{pwm_q < bright}};
`else
    assign gate = '1;
`endif

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        pend_d  = pend_q;
        pat_d   = pat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) cur_d = req;
                if (run) begin
                    state_d = ST_RUN;
                    pat_d   = NUM_LEDS'(pattern_init(cur_d, NUM_LEDS));
                end
            end
            ST_RUN: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else begin
                    if (tick) begin
                        pat_d = NUM_LEDS'(pattern_step(
                            cur_q, 32'(pat_q), NUM_LEDS));
                    end
                    // a request on a tick cycle waits for the next tick
                    if (accept) begin
                        pend_d  = req;
                        state_d = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                if (!run) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    cur_d   = pend_q;
                    pat_d   = NUM_LEDS'(pattern_init(pend_q, NUM_LEDS));
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        led_d = '0;
        if (state_d != ST_IDLE) led_d = pat_d & gate;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cur_q   <= MODE_OFF;
            pend_q  <= MODE_OFF;
            pat_q   <= '0;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            pend_q  <= pend_d;
            pat_q   <= pat_d;
            led_q   <= led_d;
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Scoreboard bench for led_pattern_sequencer (STEP_DIV=4, NUM_LEDS=5).
// Reference model tracks mode and step index and derives the pattern.
module tb_led_pattern_sequencer;

    localparam int D = 4;
    localparam int N = 5;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         run = 1'b0;
    logic         mode_valid = 1'b0;
    logic [1:0]   mode = 2'd0;
    logic         mode_ready;
    logic [N-1:0] led;
    logic         busy;
    logic         step_tick;
`ifdef LED_PWM_EN
    logic [3:0]   bright = 4'd8;
`endif

    always #5 clk = ~clk;

    led_pattern_sequencer #(
        .STEP_DIV (D),
        .NUM_LEDS (N)
    ) dut (
        .clk        (clk),
        .rst        (rst),
`ifdef LED_PWM_EN
        .bright     (bright),
`endif
        .run        (run),
        .mode_valid (mode_valid),
        .mode       (mode),
        .mode_ready (mode_ready),
        .led        (led),
        .busy       (busy),
        .step_tick  (step_tick)
    );

    typedef struct {
        logic [N-1:0] led;
        logic         busy;
        logic         rdy;
        logic         tick;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // model: 0 idle, 1 run, 2 pending; k = steps since mode was loaded
    int st = 0, cnt = 0, md = 0, pd = 0, k = 0, pwm = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    function automatic logic [N-1:0] pat_of(input int m, input int kk);
        logic [N-1:0] r;
        logic [N-1:0] one;
        one = 1;
        r = '0;
        case (m)
            1: r = (kk % 2 == 0) ? '1 : '0;
            2: r = one << (kk % N);
            3: r = N'(kk % (1 << N));
            default: r = '0;
        endcase
        return r;
    endfunction

    // drive one cycle's inputs, advance the model across the edge,
    // and queue what the DUT must show after that edge
    task automatic cycle(input logic r, input logic rn, input logic v,
                         input logic [1:0] m, output logic acc);
        bit tk;
        int pwm_pre;
        exp_t e;
        @(negedge clk);
        rst = r;
        run = rn;
        mode_valid = v;
        mode = m;
        tk = (st != 0) && (cnt == D - 1);
        acc = v && (st != 2);
        pwm_pre = pwm;
        if (r) begin
            st = 0; cnt = 0; md = 0; k = 0; pwm = 0;
        end else begin
            pwm = (pwm + 1) % 16;
            if (st == 0) begin
                if (acc) md = int'(m);
                if (rn) begin st = 1; k = 0; cnt = 0; end
            end else if (!rn) begin
                st = 0; cnt = 0;
            end else begin
                cnt = (cnt + 1) % D;
                if (st == 2) begin
                    if (tk) begin md = pd; k = 0; st = 1; end
                end else begin
                    if (tk) k++;
                    if (acc) begin pd = int'(m); st = 2; end
                end
            end
        end
        e.led = (st == 0) ? '0 : pat_of(md, k);
`ifdef LED_PWM_EN
        if (!(pwm_pre < int'(bright))) e.led = '0;
`endif
        e.busy = (st != 0);
        e.rdy  = (st != 2);
        e.tick = (st != 0) && (cnt == D - 1);
        q.push_back(e);
    endtask

    task automatic run_n(input int n);
        logic a;
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 2'd0, a);
    endtask

    task automatic after_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic chk_led(input string nm, input logic [N-1:0] exp);
`ifndef LED_PWM_EN
        chk(nm, 32'(led), 32'(exp));
`endif
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("led", 32'(led), 32'(e.led));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("mode_ready", 32'(mode_ready), 32'(e.rdy));
            chk("step_tick", 32'(step_tick), 32'(e.tick));
        end
    end

    initial begin
        logic a;
        logic hold;
        logic [1:0] hm;
        logic v;
        logic [1:0] m;
        logic rn;

        cycle(1'b1, 1'b0, 1'b0, 2'd0, a);
        cycle(1'b1, 1'b0, 1'b0, 2'd0, a);
        after_edge();
        chk("reset_led", 32'(led), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ready", 32'(mode_ready), 32'd1);

        // CHASE walk and wrap
        cycle(1'b0, 1'b0, 1'b1, 2'd2, a);
        cycle(1'b0, 1'b1, 1'b0, 2'd0, a);
        after_edge();
        chk_led("chase_init", 5'b00001);
        run_n(4);
        after_edge();
        chk_led("chase_1", 5'b00010);
        run_n(12);
        after_edge();
        chk_led("chase_4", 5'b10000);
        run_n(4);
        after_edge();
        chk_led("chase_wrap", 5'b00001);

        // COUNT full wrap
        cycle(1'b0, 1'b0, 1'b0, 2'd0, a);
        cycle(1'b0, 1'b0, 1'b1, 2'd3, a);
        cycle(1'b0, 1'b1, 1'b0, 2'd0, a);
        run_n(31 * D);
        after_edge();
        chk_led("count_max", 5'b11111);
        run_n(D);
        after_edge();
        chk_led("count_wrap", 5'b00000);

        // BLINK requested mid-step while CHASE shows 00100
        cycle(1'b0, 1'b0, 1'b0, 2'd0, a);
        cycle(1'b0, 1'b0, 1'b1, 2'd2, a);
        cycle(1'b0, 1'b1, 1'b0, 2'd0, a);
        run_n(2 * D + 1);
        cycle(1'b0, 1'b1, 1'b1, 2'd1, a);
        after_edge();
        chk("pend_ready", 32'(mode_ready), 32'd0);
        chk_led("pend_hold", 5'b00100);
        run_n(2);
        after_edge();
        chk_led("blink_apply", 5'b11111);
        chk("ready_back", 32'(mode_ready), 32'd1);
        run_n(D);
        after_edge();
        chk_led("blink_off", 5'b00000);

        // BLINK requested on the tick cycle of CHASE 00010
        cycle(1'b0, 1'b0, 1'b0, 2'd0, a);
        cycle(1'b0, 1'b0, 1'b1, 2'd2, a);
        cycle(1'b0, 1'b1, 1'b0, 2'd0, a);
        run_n(D + D - 1);
        cycle(1'b0, 1'b1, 1'b1, 2'd1, a);
        after_edge();
        chk_led("tick_req_adv", 5'b00100);
        run_n(D);
        after_edge();
        chk_led("tick_req_apply", 5'b11111);

        // drop run while pending: pending CHASE is discarded
        cycle(1'b0, 1'b1, 1'b1, 2'd2, a);
        cycle(1'b0, 1'b0, 1'b0, 2'd0, a);
        after_edge();
        chk("drop_busy", 32'(busy), 32'd0);
        chk("drop_led", 32'(led), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 2'd0, a);
        after_edge();
        chk_led("resume_old", 5'b11111);

        // randomized traffic, mode held stable while back-pressured
        hold = 1'b0;
        hm = 2'd0;
        for (int i = 0; i < 1500; i++) begin
            if (hold) begin
                v = 1'b1;
                m = hm;
            end else begin
                v = ($urandom_range(0, 4) == 0);
                m = 2'($urandom_range(0, 3));
            end
            rn = ($urandom_range(0, 19) != 0);
            if ($urandom_range(0, 299) == 0) begin
                cycle(1'b1, rn, v, m, a);
                hold = 1'b0;
            end else begin
                cycle(1'b0, rn, v, m, a);
                hold = v && !a;
            end
            hm = m;
        end

        begin
            int w;
            w = 0;
            while (q.size() > 0 && w < 10) begin
                @(negedge clk);
                w++;
            end
            if (q.size() > 0) begin
                total++;
                bad++;
                $display("FAIL drain: %0d entries left, expected 0",
                         q.size());
            end
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_pattern_sequencer.md
# led_pattern_sequencer

Controller that owns the board LED bank and sequences it through selectable patterns: off, blink, chase and binary count. A prescaler divides the 50 MHz `clk` down to a step rate. A small FSM applies mode changes only at step boundaries, so patterns never glitch mid-step. Upstream control logic (buttons, UART command decoder) requests modes through a valid/ready handshake; the block drives the LED pins directly.

## Interface
- `STEP_DIV`, 12_500_000, clk cycles per pattern step (4 Hz at 50 MHz); must be ≥ 2
- `NUM_LEDS`, 5, LED outputs driven; must be ≥ 2
- `clk`  in  1  single clock, 50 MHz
- `rst`  in  1  synchronous, active-high reset
- `run`  in  1  level; 1 = sequence, 0 = idle with LEDs dark
- `mode_valid`  in  1  mode request present
- `mode`  in  2  requested mode: 0 OFF, 1 BLINK, 2 CHASE, 3 COUNT
- `mode_ready`  out  1  request accepted on a cycle where valid && ready
- `led`  out  NUM_LEDS  LED drive, registered
- `busy`  out  1  high when state ≠ IDLE
- `step_tick`  out  1  one-cycle pulse on every pattern step

## Operation
- Reset values: state IDLE, current mode OFF, pattern 0, `led` 0, `step_tick` 0, prescaler 0; `busy` 0 and `mode_ready` 1 (both decoded from state).
- FSM states: IDLE, RUN, PEND.
  - IDLE: prescaler held at 0; `led`=0; `mode_ready`=1. An accepted mode loads the current mode immediately. `run`=1 → RUN and loads the init pattern of the current mode.
  - RUN: prescaler counts 0..STEP_DIV-1 and wraps. At count STEP_DIV-1, `step_tick`=1 and the pattern advances. `mode_ready`=1; an accepted mode is stored as pending → PEND.
  - PEND: counts and steps as in RUN; `mode_ready`=0. At the next `step_tick`, the pending mode becomes current, the pattern loads its init value instead of advancing, and the FSM returns to RUN.
- `run`=0 in RUN or PEND → IDLE next cycle. It overrides every other event: any pending mode is discarded, the current mode is kept, `led` goes to 0.
- Init and step rules, pattern is NUM_LEDS bits:
  - OFF: init 0, step 0.
  - BLINK: init all ones, step bitwise invert.
  - CHASE: init bit0 set, step rotate left (MSB wraps to bit0).
  - COUNT: init 0, step +1 modulo 2^NUM_LEDS (wraps silently).
- `led` = pattern while in RUN or PEND; 0 in IDLE.

## Timing
- `run` sampled high at edge k in IDLE → state RUN and `led`=init pattern after edge k.
- The prescaler restarts from 0 on entering RUN. First `step_tick` is high during the STEP_DIV-th cycle in RUN. The pattern update is visible after that edge, and subsequent steps follow every STEP_DIV cycles.
- Mode accepted in RUN at edge k → PEND after k. It is applied at the next tick edge: latency is 1..STEP_DIV cycles.
- Mode accepted on the same edge as a `step_tick` in RUN: that tick advances the old pattern, and the new mode applies at the following tick (one full step later).
- Mode changes while in PEND are back-pressured (`mode_ready`=0). `mode` must be held stable while `mode_valid`=1 and not accepted.
- `rst` mid-operation returns all state to reset values on the next edge, regardless of `run`.

## Configuration
- `LED_PWM_EN` defined:
  - Adds input `bright` (4 bits) and a free-running 4-bit PWM counter, reset 0.
  - `led` = pattern AND (pwm_cnt < `bright`), applied per bit and registered.
  - `bright`=0 → dark; `bright`=15 → 15/16 duty.
  - IDLE still forces `led`=0.
- `LED_PWM_EN` undefined: no `bright` port and no PWM counter; `led` = pattern directly.

## Structure
- Package `led_seq_pkg`:
  - mode enum (OFF/BLINK/CHASE/COUNT) and FSM state enum
  - functions `pattern_init(mode)` and `pattern_step(mode, pattern)`
  - PWM width constant (4)
- Sub-module `led_step_prescaler`: the STEP_DIV counter, with a clear input and a `tick` output. It is instantiated once, and its clear is asserted in IDLE.

## Test plan
- Bench parameters for all scenarios: STEP_DIV=4, NUM_LEDS=5.
- Reset, mode=CHASE accepted in IDLE, then `run`=1: `led` 00001; after each 4 cycles 00010, 00100, 01000, 10000, then wraps to 00001.
- COUNT mode, run 32 steps: `led` 00000..11111, then back to 00000 on the 32nd tick.
- CHASE at 00100, BLINK accepted mid-step: `mode_ready`=0 until the tick. At the tick `led`=11111, next tick 00000, `mode_ready`=1 again.
- BLINK mode accepted on the same cycle as `step_tick` in CHASE 00010: next tick gives 00100, and only the following tick gives 11111.
- In PEND, drop `run`: next cycle state IDLE, `led`=0, `busy`=0. Raise `run` again: the old mode's init pattern appears, confirming the pending mode was discarded.
- With `LED_PWM_EN`, BLINK mode, `bright`=8: LEDs on for exactly 8 of every 16 cycles while the pattern is all ones. Without the macro, `led` is constant between ticks.
